// File: rtl/command_encoder.sv
// command_encoder: serialises one drawing command per handshake onto the
// 8-bit command link, one byte per clock, with decoder guard/gap bytes.
// Ports:
//   clk        in  1  rising-edge clock
//   rst        in  1  async active-high reset
//   cmd_valid  in  1  command present
//   cmd_ready  out 1  accepting (IDLE only)
//   cmd_op     in  2  00 NOOP 01 PIXEL/CLEAR 10 LINE 11 RECT
//   cmd_x1     in  3  x1 (x1==7 with op 01 is CLEAR)
//   cmd_y1     in  3  y1
//   cmd_p2     in  3  x2 / width
//   cmd_p3     in  3  y2 / height
//   tx_byte    out 8  registered link byte
//   tx_busy    out 1  frame (incl. guard/gap) in progress
//   frame_done out 1  high on the last byte of a frame
module command_encoder #(
   parameter int IDLE_GAP = 0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic [1:0] cmd_op,
   input  logic [2:0] cmd_x1,
   input  logic [2:0] cmd_y1,
   input  logic [2:0] cmd_p2,
   input  logic [2:0] cmd_p3,
   output logic [7:0] tx_byte,
   output logic       tx_busy,
   output logic       frame_done
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_X1,
      S_Y1,
      S_P2,
      S_P3,
      S_GUARD,
      S_GAP
   } state_t;

   localparam logic [1:0] OP_NOOP = 2'b00;
   localparam logic [1:0] OP_PIX  = 2'b01;
   localparam bit HAS_GAP = (IDLE_GAP > 0);
   localparam logic [3:0] GAP_LAST =
      4'((IDLE_GAP > 0) ? IDLE_GAP - 1 : 0);
   // Where a frame goes once its last real byte is out.
   localparam state_t S_AFTER = HAS_GAP ? S_GAP : S_IDLE;

   state_t     state_q;
   state_t     state_d;
   logic [1:0] op_q;
   logic [2:0] x1_q;
   logic [2:0] y1_q;
   logic [2:0] p2_q;
   logic [2:0] p3_q;
   logic [3:0] gap_q;
   logic [7:0] byte_d;
   logic       accept;
   logic       is_clear;

   function automatic logic [7:0] param_byte(
      input logic [2:0] v
   );
      return {3'b000, v, 2'b00};
   endfunction

   assign accept   = cmd_valid && cmd_ready;
   assign is_clear = (x1_q == 3'd7);

   // State register and registered link byte.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         tx_byte <= 8'h00;
      end else begin
         state_q <= state_d;
         tx_byte <= byte_d;
      end
   end

   // Command capture: later input changes are ignored.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         op_q <= 2'b00;
         x1_q <= 3'd0;
         y1_q <= 3'd0;
         p2_q <= 3'd0;
         p3_q <= 3'd0;
      end else if (accept) begin
         op_q <= cmd_op;
         x1_q <= cmd_x1;
         y1_q <= cmd_y1;
         p2_q <= cmd_p2;
         p3_q <= cmd_p3;
      end
   end

   // Gap counter: loaded on GAP entry, counts down to the last gap byte.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         gap_q <= 4'd0;
      end else if (state_d == S_GAP && state_q != S_GAP) begin
         gap_q <= GAP_LAST;
      end else if (state_q == S_GAP && gap_q != 4'd0) begin
         gap_q <= gap_q - 4'd1;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE: begin
            if (accept) state_d = S_START;
         end
         S_START: state_d = S_X1;
         S_X1: begin
            if (op_q == OP_NOOP) begin
               state_d = S_AFTER;
            end else if (op_q == OP_PIX && is_clear) begin
               state_d = S_GUARD;
            end else begin
               state_d = S_Y1;
            end
         end
         S_Y1: begin
            if (op_q == OP_PIX) state_d = S_GUARD;
            else state_d = S_P2;
         end
         S_P2:    state_d = S_P3;
         S_P3:    state_d = S_GUARD;
         S_GUARD: state_d = S_AFTER;
         S_GAP: begin
            if (gap_q == 4'd0) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Output logic. START is only entered from IDLE on accept,
   // so its op comes straight from the input being captured.
   always_comb begin
      byte_d = 8'h00;
      unique case (state_d)
         S_START: byte_d = {1'b1, cmd_op, 5'b00000};
         S_X1: begin
            if (op_q == OP_NOOP) byte_d = 8'h00;
            else byte_d = param_byte(x1_q);
         end
         S_Y1:    byte_d = param_byte(y1_q);
         S_P2:    byte_d = param_byte(p2_q);
         S_P3:    byte_d = param_byte(p3_q);
         default: byte_d = 8'h00;
      endcase
   end

   always_comb begin
      cmd_ready = (state_q == S_IDLE) && !rst;
      tx_busy   = (state_q != S_IDLE);
      if (HAS_GAP) begin
         frame_done = (state_q == S_GAP) && (gap_q == 4'd0);
      end else begin
         frame_done = (state_q == S_GUARD) ||
                      (state_q == S_X1 && op_q == OP_NOOP);
      end
   end

endmodule
